// File: rtl/key_expand_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : key_expand_seq_if
// Brief    : Control/key/read-port bundle between the cipher and the AES
//            key-schedule engine. Carries rk_inv when KEYEXP_DECRYPT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
interface key_expand_seq_if #(
  parameter int MAX_KEY_BITS = 256
);
  logic                    start;
  logic [1:0]              key_len;
  logic [MAX_KEY_BITS-1:0] key_in;
  logic                    busy;
  logic                    done;
  logic                    keys_valid;
  logic                    rk_rd_en;
  logic [3:0]              rk_idx;
  logic [127:0]            rk_out;
  logic                    rk_vld;
`ifdef KEYEXP_DECRYPT_EN
  logic                    rk_inv;

  modport master (
    output start, key_len, key_in, rk_rd_en, rk_idx, rk_inv,
    input  busy, done, keys_valid, rk_out, rk_vld
  );
  modport slave (
    input  start, key_len, key_in, rk_rd_en, rk_idx, rk_inv,
    output busy, done, keys_valid, rk_out, rk_vld
  );
`else
  modport master (
    output start, key_len, key_in, rk_rd_en, rk_idx,
    input  busy, done, keys_valid, rk_out, rk_vld
  );
  modport slave (
    input  start, key_len, key_in, rk_rd_en, rk_idx,
    output busy, done, keys_valid, rk_out, rk_vld
  );
`endif
endinterface
`default_nettype wire

// File: rtl/key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module   : key_expand_seq
// Brief    : Iterative AES-128/192/256 key schedule, one word per clock, with
//            a registered round-key read port. KEYEXP_DECRYPT_EN adds
//            InvMixColumns round keys for the equivalent inverse cipher.
// Revision : 1.0 - initial release
// ============================================================================

module key_expand_sbox (
  input  wire  [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  always_comb begin
    x2   = gmul(in_byte, in_byte);
    x3   = gmul(x2, in_byte);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, in_byte);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, in_byte);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, in_byte);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, in_byte);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, in_byte);
    inv  = gmul(x127, x127);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module key_expand_seq #(
  parameter int MAX_KEY_BITS = 256
) (
  input wire               clk,
  input wire               rst_n,
  key_expand_seq_if.slave  bus
);
  localparam int NK_MAX = MAX_KEY_BITS / 32;
  localparam int T_MAX  = 4 * (NK_MAX + 7);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [0:0]   state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [3:0]   pos_q, pos_d;
  logic [3:0]   nk_q, nk_d;
  logic [3:0]   nr_q, nr_d;
  logic [5:0]   t_q, t_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         keys_valid_q, keys_valid_d;
  logic         done_q, done_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic         rk_vld_q, rk_vld_d;
  logic [31:0]  mem_q [T_MAX];
  logic [31:0]  mem_d [T_MAX];

  logic         len_ok, accept, expand_en, busy, last_word;
  logic [3:0]   nk_sel, nr_sel;
  logic [5:0]   t_sel;
  logic [31:0]  temp_prev, w_back, sub_in, sub_out, temp_new, new_word;

  always_comb begin
    len_ok = 1'b0;
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    t_sel  = 6'd44;
    case (bus.key_len)
      2'b00: len_ok = 1'b1;
      2'b01: begin len_ok = (MAX_KEY_BITS >= 192); nk_sel = 4'd6; nr_sel = 4'd12; t_sel = 6'd52; end
      2'b10: begin len_ok = (MAX_KEY_BITS >= 256); nk_sel = 4'd8; nr_sel = 4'd14; t_sel = 6'd60; end
      default: len_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start && len_ok) state_d = ST_EXPAND;
      ST_EXPAND: if (last_word) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state_q == ST_IDLE) && bus.start && len_ok;
    expand_en = (state_q == ST_EXPAND);
    busy      = expand_en;
  end

  // pos_q tracks i mod Nk so the Nk=6 case needs no divider.
  always_comb begin
    temp_prev = mem_q[i_q - 6'd1];
    w_back    = mem_q[i_q - {2'b00, nk_q}];
    sub_in    = (pos_q == 4'd0) ? {temp_prev[23:0], temp_prev[31:24]} : temp_prev;
    if (pos_q == 4'd0)                       temp_new = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && pos_q == 4'd4)  temp_new = sub_out;
    else                                     temp_new = temp_prev;
    new_word  = w_back ^ temp_new;
    last_word = expand_en && (i_q == t_q - 6'd1);
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    key_expand_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    i_d          = i_q;
    pos_d        = pos_q;
    nk_d         = nk_q;
    nr_d         = nr_q;
    t_d          = t_q;
    rcon_d       = rcon_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    mem_d        = mem_q;
    if (accept) begin
      for (int j = 0; j < NK_MAX; j++) begin
        if (j < int'(nk_sel)) mem_d[j] = bus.key_in[MAX_KEY_BITS-1-32*j -: 32];
      end
      i_d          = {2'b00, nk_sel};
      pos_d        = 4'd0;
      nk_d         = nk_sel;
      nr_d         = nr_sel;
      t_d          = t_sel;
      rcon_d       = 8'h01;
      keys_valid_d = 1'b0;
    end else if (expand_en) begin
      mem_d[i_q] = new_word;
      i_d        = i_q + 6'd1;
      pos_d      = (pos_q == nk_q - 4'd1) ? 4'd0 : pos_q + 4'd1;
      if (pos_q == 4'd0) rcon_d = xtime(rcon_q);
      if (last_word) begin
        done_d       = 1'b1;
        keys_valid_d = 1'b1;
      end
    end
  end

`ifdef KEYEXP_DECRYPT_EN
  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = w[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  logic         rd_ok;
  logic [5:0]   rd_base;
  logic [127:0] fwd_key, rd_key;

  // Out-of-range indices are clamped so the store is never read past T-1.
  always_comb begin
    rd_ok   = bus.rk_rd_en && keys_valid_q && (bus.rk_idx <= nr_q);
    rd_base = (bus.rk_idx <= nr_q) ? {bus.rk_idx, 2'b00} : 6'd0;
    fwd_key = {mem_q[rd_base], mem_q[rd_base + 6'd1],
               mem_q[rd_base + 6'd2], mem_q[rd_base + 6'd3]};
`ifdef KEYEXP_DECRYPT_EN
    if (bus.rk_inv && bus.rk_idx != 4'd0 && bus.rk_idx < nr_q)
      rd_key = {inv_mix_word(fwd_key[127:96]), inv_mix_word(fwd_key[95:64]),
                inv_mix_word(fwd_key[63:32]),  inv_mix_word(fwd_key[31:0])};
    else
      rd_key = fwd_key;
`else
    rd_key = fwd_key;
`endif
    rk_vld_d = rd_ok;
    if (rd_ok)             rk_out_d = rd_key;
    else if (bus.rk_rd_en) rk_out_d = 128'h0;
    else                   rk_out_d = rk_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q          <= 6'd0;
      pos_q        <= 4'd0;
      nk_q         <= 4'd4;
      nr_q         <= 4'd10;
      t_q          <= 6'd44;
      rcon_q       <= 8'h01;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      rk_out_q     <= 128'h0;
      rk_vld_q     <= 1'b0;
    end else begin
      i_q          <= i_d;
      pos_q        <= pos_d;
      nk_q         <= nk_d;
      nr_q         <= nr_d;
      t_q          <= t_d;
      rcon_q       <= rcon_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
      rk_out_q     <= rk_out_d;
      rk_vld_q     <= rk_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_out     = rk_out_q;
  assign bus.rk_vld     = rk_vld_q;
endmodule
`default_nettype wire

// File: tb/tb_key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_expand_seq
// Brief    : Self-checking bench for key_expand_seq with a reference key
//            schedule model and a round-key scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_expand_seq;
  localparam int MAX_KEY_BITS = 256;
  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_expand_seq_if #(.MAX_KEY_BITS(MAX_KEY_BITS)) bus ();
  key_expand_seq #(.MAX_KEY_BITS(MAX_KEY_BITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;
  logic [7:0]   sb [256];
  logic [31:0]  ref_w [60];
  int           ref_nr;
  logic [128:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // S-box built from generator 3 log/antilog walk, independent of the DUT's inverse chain.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input logic [1:0] len);
    int nk, t;
    logic [31:0] tmp;
    logic [7:0] rc;
    nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
    ref_nr = nk + 6;
    t = 4 * (ref_nr + 1);
    rc = 8'h01;
    for (int k = 0; k < nk; k++) ref_w[k] = key[255-32*k -: 32];
    for (int k = nk; k < t; k++) begin
      tmp = ref_w[k-1];
      if (k % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (nk == 8 && k % nk == 4) begin
        tmp = subw(tmp);
      end
      ref_w[k] = ref_w[k-nk] ^ tmp;
    end
  endtask

  function automatic logic [127:0] rkey(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

`ifdef KEYEXP_DECRYPT_EN
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_ref(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] coef [4];
    logic [7:0] o;
    logic [31:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int k = 0; k < 4; k++) a[k] = w[31-8*k -: 8];
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      o = 8'h00;
      for (int c = 0; c < 4; c++) o = o ^ gm(a[c], coef[(c - r + 4) % 4]);
      res[31-8*r -: 8] = o;
    end
    return res;
  endfunction
`endif

  task automatic do_start(input logic [255:0] key, input logic [1:0] len);
    bus.key_in  = key;
    bus.key_len = len;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.keys_valid !== 1'b0) begin failures++; $display("FAIL reset_keys_valid: got %b want 0", bus.keys_valid); end
    checks++; if (bus.rk_vld !== 1'b0) begin failures++; $display("FAIL reset_rk_vld: got %b want 0", bus.rk_vld); end
    checks++; if (bus.rk_out !== 128'h0) begin failures++; $display("FAIL reset_rk_out: got %h want 0", bus.rk_out); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    do_start(KEY128, 2'b11);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL illegal_busy: got %b want 0", bus.busy); end
    checks++; if (bus.keys_valid !== 1'b0) begin failures++; $display("FAIL illegal_keys_valid: got %b want 0", bus.keys_valid); end
    bus.rk_rd_en = 1'b1; bus.rk_idx = 4'd0;
    tick();
    bus.rk_rd_en = 1'b0;
    checks++; if (bus.rk_vld !== 1'b0) begin failures++; $display("FAIL read_no_keys: got %b want 0", bus.rk_vld); end
  endtask

  task automatic test_expand(input logic [255:0] key, input logic [1:0] len, input int exp_edges, input bit mid_start);
    int n;
    bit got;
    model_expand(key, len);
    do_start(key, len);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL expand_busy: got %b want 1", bus.busy); end
    n = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      if (mid_start && n == 10) begin bus.key_in = ~key; bus.start = 1'b1; end
      if (n == 5) begin bus.rk_rd_en = 1'b1; bus.rk_idx = 4'd0; end
      tick();
      n++;
      bus.start = 1'b0;
      bus.rk_rd_en = 1'b0;
      if (n == 6) begin
        checks++; if (bus.rk_vld !== 1'b0) begin failures++; $display("FAIL read_busy_vld: got %b want 0", bus.rk_vld); end
      end
      if (bus.done === 1'b1) got = 1'b1;
    end
    checks++; if (!got || n != exp_edges) begin failures++; $display("FAIL done_latency: got %0d want %0d", n, exp_edges); end
    checks++; if (bus.keys_valid !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL done_state: got kv=%b busy=%b want kv=1 busy=0", bus.keys_valid, bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_kat(input logic [3:0] idx, input logic exp_vld, input logic [127:0] exp_key);
    bus.rk_rd_en = 1'b1;
    bus.rk_idx = idx;
    tick();
    bus.rk_rd_en = 1'b0;
    checks++; if (bus.rk_vld !== exp_vld) begin failures++; $display("FAIL kat_vld_%0d: got %b want %b", idx, bus.rk_vld, exp_vld); end
    checks++; if (bus.rk_out !== exp_key) begin failures++; $display("FAIL kat_key_%0d: got %h want %h", idx, bus.rk_out, exp_key); end
  endtask

  // Back-to-back reads of every round, one past Nr, a repeat, then an idle hold cycle.
  task automatic test_reads();
    logic [128:0] e;
    for (int c = 0; c <= ref_nr + 3; c++) begin
      if (c <= ref_nr + 1) begin
        bus.rk_rd_en = 1'b1;
        bus.rk_idx = 4'(c);
        exp_q.push_back((c <= ref_nr) ? {1'b1, rkey(c)} : {1'b0, 128'h0});
      end else if (c == ref_nr + 2) begin
        bus.rk_rd_en = 1'b1;
        bus.rk_idx = 4'd1;
        exp_q.push_back({1'b1, rkey(1)});
      end else begin
        bus.rk_rd_en = 1'b0;
        exp_q.push_back({1'b0, rkey(1)});
      end
      tick();
      e = exp_q.pop_front();
      checks++; if (bus.rk_vld !== e[128]) begin failures++; $display("FAIL read_vld_c%0d: got %b want %b", c, bus.rk_vld, e[128]); end
      checks++; if (bus.rk_out !== e[127:0]) begin failures++; $display("FAIL read_key_c%0d: got %h want %h", c, bus.rk_out, e[127:0]); end
    end
    bus.rk_rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_start(KEY256, 2'b10);
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.keys_valid !== 1'b0)
      begin failures++; $display("FAIL midreset_ctrl: got busy=%b done=%b kv=%b want 0", bus.busy, bus.done, bus.keys_valid); end
    checks++; if (bus.rk_vld !== 1'b0 || bus.rk_out !== 128'h0)
      begin failures++; $display("FAIL midreset_rk: got vld=%b out=%h want 0", bus.rk_vld, bus.rk_out); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.keys_valid !== 1'b0)
      begin failures++; $display("FAIL midreset_after: got busy=%b kv=%b want 0", bus.busy, bus.keys_valid); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(KEY192, 2'b01);
    n = 0;
    while (n < 200 && bus.done !== 1'b1) begin tick(); n++; end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL b2b_first_done: got %b want 1", bus.done); end
    model_expand(KEY128, 2'b00);
    do_start(KEY128, 2'b00);
    checks++; if (bus.busy !== 1'b1 || bus.keys_valid !== 1'b0)
      begin failures++; $display("FAIL b2b_accept: got busy=%b kv=%b want busy=1 kv=0", bus.busy, bus.keys_valid); end
    n = 0;
    while (n < 200 && bus.done !== 1'b1) begin tick(); n++; end
    checks++; if (n != 40) begin failures++; $display("FAIL b2b_latency: got %0d want 40", n); end
  endtask

`ifdef KEYEXP_DECRYPT_EN
  task automatic test_decrypt();
    logic [127:0] k5;
    k5 = rkey(5);
    bus.rk_inv = 1'b1;
    test_kat(4'd0, 1'b1, rkey(0));
    test_kat(4'd10, 1'b1, rkey(10));
    test_kat(4'd5, 1'b1, {inv_mix_ref(k5[127:96]), inv_mix_ref(k5[95:64]),
                          inv_mix_ref(k5[63:32]), inv_mix_ref(k5[31:0])});
    bus.rk_inv = 1'b0;
    test_kat(4'd5, 1'b1, k5);
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.key_len = 2'b00;
    bus.key_in = '0;
    bus.rk_rd_en = 1'b0;
    bus.rk_idx = 4'd0;
`ifdef KEYEXP_DECRYPT_EN
    bus.rk_inv = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_illegal();
    test_expand(KEY128, 2'b00, 40, 1'b1);
    test_kat(4'd1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);
    test_kat(4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    test_kat(4'd11, 1'b0, 128'h0);
    test_reads();
    test_expand(KEY192, 2'b01, 46, 1'b0);
    test_kat(4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
    test_reads();
    test_expand(KEY256, 2'b10, 52, 1'b0);
    test_kat(4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
    test_reads();
    test_reset_mid();
    test_expand(KEY256, 2'b10, 52, 1'b0);
    test_reads();
    test_back_to_back();
    test_reads();
`ifdef KEYEXP_DECRYPT_EN
    test_decrypt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
